// File: rtl/comparator_seq_param.sv
// Multi-cycle magnitude comparator: compares WIDTH-bit operands MSB-first,
// DIGIT bits per cycle, stopping at the first unequal slice.
module comparator_seq_param #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             g,
  output logic             l
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]    LAST = IW'(N - 1);
  localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CMP  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IW-1:0]    idx;
  logic             slice_gt;
  logic             slice_lt;

  // Bit-level equality chain across one slice; returns {gt, lt}.
  function automatic logic [1:0] slice_cmp(input logic [DIGIT-1:0] x,
                                           input logic [DIGIT-1:0] y);
    logic eq_chain;
    logic gt;
    logic lt;
    eq_chain = 1'b1;
    gt       = 1'b0;
    lt       = 1'b0;
    for (int j = DIGIT - 1; j >= 0; j--) begin
      gt       = gt | (eq_chain & x[j] & ~y[j]);
      lt       = lt | (eq_chain & ~x[j] & y[j]);
      eq_chain = eq_chain & ~(x[j] ^ y[j]);
    end
    return {gt, lt};
  endfunction

  // Operands are shifted left after each equal slice, so the slice under test
  // always sits at the top of the operand registers.
  always_comb begin
    {slice_gt, slice_lt} = slice_cmp(op_a[WIDTH-1 -: DIGIT], op_b[WIDTH-1 -: DIGIT]);
  end

  // Control FSM, operand shift registers and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      e     <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping both sign bits maps two's complement onto offset binary.
            op_a  <= a ^ ({WIDTH{signed_mode}} & MSB);
            op_b  <= b ^ ({WIDTH{signed_mode}} & MSB);
            idx   <= '0;
            busy  <= 1'b1;
            state <= CMP;
          end else begin
            state <= IDLE;
          end
        end
        CMP: begin
          if (slice_gt || slice_lt) begin
            g     <= slice_gt;
            l     <= slice_lt;
            e     <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == LAST) begin
            e     <= 1'b1;
            g     <= 1'b0;
            l     <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx   <= idx + IW'(1);
            op_a  <= op_a << DIGIT;
            op_b  <= op_b << DIGIT;
            state <= CMP;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq_param.sv
// Scoreboard bench for comparator_seq_param at DIGIT = 1, 4 and 16 (WIDTH = 16).
module tb_comparator_seq_param;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sm = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic busy1, done1, e1, g1, l1;
  logic busy4, done4, e4, g4, l4;
  logic busy16, done16, e16, g16, l16;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic e;
    logic g;
    logic l;
    int   lat;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q16[$];

  comparator_seq_param #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy1), .done(done1), .e(e1), .g(g1), .l(l1));
  comparator_seq_param #(.WIDTH(16), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy4), .done(done4), .e(e4), .g(g4), .l(l4));
  comparator_seq_param #(.WIDTH(16), .DIGIT(16)) u16 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy16), .done(done16), .e(e16), .g(g16), .l(l16));

  always #5 clk = ~clk;

  // Reference: direct compare, latency from the highest differing bit.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input int dg);
    exp_t r;
    logic [15:0] d;
    int p;
    if (s) begin
      r.g = ($signed(x) > $signed(y));
      r.l = ($signed(x) < $signed(y));
    end else begin
      r.g = (x > y);
      r.l = (x < y);
    end
    r.e = (x == y);
    d = x ^ y;
    p = 0;
    for (int i = 0; i < W; i++) if (d[i]) p = i;
    r.lat = (d == 16'h0000) ? (W / dg) : ((W - 1 - p) / dg + 1);
    return r;
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sm = s; start = 1'b1;
    q4.push_back(model(x, y, s, 4));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done4; lat = edges since the start edge, -1 on timeout.
  task automatic wait_done4(input int cnt0, output int lat);
    lat = -1;
    for (int c = cnt0; c <= 24; c++) begin
      if (done4) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy4, done4, e4, g4, l4, busy1, done1, e1, g1, l1, busy16, done16, e16, g16, l16} !== 15'h0) begin
      failures++;
      $display("FAIL reset_state: got u4=%b u1=%b u16=%b required all 0",
               {busy4, done4, e4, g4, l4}, {busy1, done1, e1, g1, l1}, {busy16, done16, e16, g16, l16});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_equal();
    exp_t x;
    int bad;
    issue(16'h1234, 16'h1234, 1'b0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy4 !== 1'b1 || done4 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL equal_busy: %0d bad cycles among edges 0-3, required busy=1 done=0", bad);
    end
    x = q4.pop_front();
    checks++;
    if ({done4, busy4, e4, g4, l4} !== {1'b1, 1'b0, x.e, x.g, x.l}) begin
      failures++;
      $display("FAIL equal_done: got done,busy,e,g,l=%b required %b",
               {done4, busy4, e4, g4, l4}, {1'b1, 1'b0, x.e, x.g, x.l});
    end
  endtask

  task automatic test_unsigned_signed();
    logic [15:0] ta [4] = '{16'h8000, 16'h1233, 16'hFFFF, 16'hFFFF};
    logic [15:0] tb [4] = '{16'h7FFF, 16'h1234, 16'h0001, 16'h0001};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_t x;
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], ts[i]);
      wait_done4(0, lat);
      x = q4.pop_front();
      checks++;
      if (lat != x.lat) begin
        failures++;
        $display("FAIL latency_%0d: got %0d required %0d", i, lat, x.lat);
      end
      checks++;
      if ({e4, g4, l4} !== {x.e, x.g, x.l}) begin
        failures++;
        $display("FAIL result_%0d: got egl=%b required %b", i, {e4, g4, l4}, {x.e, x.g, x.l});
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t x;
    int lat;
    int extra;
    issue(16'h00F0, 16'h00F1, 1'b0);
    @(negedge clk);
    a = 16'h0000; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hFFFF;
    wait_done4(1, lat);
    x = q4.pop_front();
    checks++;
    if (lat != x.lat || {e4, g4, l4} !== {x.e, x.g, x.l}) begin
      failures++;
      $display("FAIL busy_ignore: got lat=%0d egl=%b required lat=%0d egl=%b",
               lat, {e4, g4, l4}, x.lat, {x.e, x.g, x.l});
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_ignore_extra_done: got %0d extra done pulses required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy4, done4, e4, g4, l4} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_abort_state: got busy,done,e,g,l=%b required 00000", {busy4, done4, e4, g4, l4});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_abort_done: got %0d done pulses required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int lat;
    issue(16'h8000, 16'h7FFF, 1'b0);
    wait_done4(0, lat);
    x = q4.pop_front();
    checks++;
    if (lat != x.lat || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d busy=%b required lat=%0d busy=0", lat, busy4, x.lat);
    end
    issue(16'h0010, 16'h0001, 1'b0);
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b required busy=1 done=0", busy4, done4);
    end
    wait_done4(0, lat);
    x = q4.pop_front();
    checks++;
    if (lat != x.lat || {e4, g4, l4} !== {x.e, x.g, x.l}) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d egl=%b required lat=%0d egl=%b",
               lat, {e4, g4, l4}, x.lat, {x.e, x.g, x.l});
    end
  endtask

  task automatic test_random_sweep();
    logic [15:0] ra, rb;
    logic rs;
    int l1c, l4c, l16c, bad;
    exp_t x;
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int it = 0; it < 40; it++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (16'h0001 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      rs = 1'($urandom_range(0, 1));
      @(negedge clk);
      a = ra; b = rb; sm = rs; start = 1'b1;
      q1.push_back(model(ra, rb, rs, 1));
      q4.push_back(model(ra, rb, rs, 4));
      q16.push_back(model(ra, rb, rs, 16));
      @(posedge clk); #1;
      start = 1'b0;
      l1c = -1; l4c = -1; l16c = -1;
      for (int c = 0; c <= 24; c++) begin
        if (done1 && l1c < 0) begin
          l1c = c; x = q1.pop_front();
          if (c != x.lat || {e1, g1, l1} !== {x.e, x.g, x.l}) begin
            bad++;
            $display("FAIL sweep_d1: a=%h b=%h s=%b got lat=%0d egl=%b required lat=%0d egl=%b",
                     ra, rb, rs, c, {e1, g1, l1}, x.lat, {x.e, x.g, x.l});
          end
        end
        if (done4 && l4c < 0) begin
          l4c = c; x = q4.pop_front();
          if (c != x.lat || {e4, g4, l4} !== {x.e, x.g, x.l}) begin
            bad++;
            $display("FAIL sweep_d4: a=%h b=%h s=%b got lat=%0d egl=%b required lat=%0d egl=%b",
                     ra, rb, rs, c, {e4, g4, l4}, x.lat, {x.e, x.g, x.l});
          end
        end
        if (done16 && l16c < 0) begin
          l16c = c; x = q16.pop_front();
          if (c != x.lat || {e16, g16, l16} !== {x.e, x.g, x.l}) begin
            bad++;
            $display("FAIL sweep_d16: a=%h b=%h s=%b got lat=%0d egl=%b required lat=%0d egl=%b",
                     ra, rb, rs, c, {e16, g16, l16}, x.lat, {x.e, x.g, x.l});
          end
        end
        if (l1c >= 0 && l4c >= 0 && l16c >= 0) break;
        @(posedge clk); #1;
      end
      if (l1c < 0 || l4c < 0 || l16c < 0) begin
        bad++;
        $display("FAIL sweep_timeout: a=%h b=%h got lat1=%0d lat4=%0d lat16=%0d required done from all",
                 ra, rb, l1c, l4c, l16c);
        q1.delete(); q4.delete(); q16.delete();
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL random_sweep: got %0d bad operations required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_unsigned_signed();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
